spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI slave front-end that sits directly upstream of the single-port command RAM.
- Deserialises MOSI frames into 10-bit command words (cmd[9:8] + payload[7:0]) and pulses rx_valid to the RAM.
- On a read-data command, it captures the RAM's 8-bit response (tx_valid/tx_data) and serialises it onto MISO.
- The SPI bit clock is the system clock clk. SS_n frames each transaction.

Parameters:
- RX_WIDTH, 10, width of command word delivered to the RAM.
- TX_WIDTH, 8, width of read data returned by the RAM.

Ports:
- clk  in  1  system clock; also the SPI bit clock, with MOSI sampled on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- SS_n  in  1  slave select, active-low; a high level aborts any frame.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  RX_WIDTH  command word to the RAM.
- rx_valid  out  1  one-cycle strobe qualifying rx_data.
- tx_data  in  TX_WIDTH  read data from the RAM.
- tx_valid  in  1  strobe qualifying tx_data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter=0, rd_addr_seen=0.
  - MISO=0, rx_data=0, rx_valid=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. All states are registered.
- In any state other than IDLE, SS_n=1 sampled at an edge gives:
  - next state IDLE, counter cleared, MISO=0;
  - no rx_valid issued, and rd_addr_seen unchanged.
- IDLE: SS_n=0 -> CHK_CMD.
- CHK_CMD: MOSI sampled as the rd/wr bit; this bit is not part of rx_data.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE and READ_ADD: shift in 10 MOSI bits, MSB first (rx_data[9] first).
  - At the 10th sampling edge, rx_data is loaded with the full word and rx_valid=1 for exactly one cycle.
  - READ_ADD additionally sets rd_addr_seen=1 at that edge.
  - The state then holds with no further capture until SS_n=1.
- READ_DATA, shift phase: shift in 10 bits and pulse rx_valid as above.
- READ_DATA, wait phase: wait for tx_valid.
  - The RAM responds 1 cycle after rx_valid; the wait has no timeout.
  - At the tx_valid edge, latch tx_data and drive MISO <= tx_data[7].
- READ_DATA, output phase: the following 7 edges drive tx_data[6]..tx_data[0].
  - After bit 0 has been held one cycle, MISO=0 and rd_addr_seen is cleared.
  - The state then holds until SS_n=1.
- No command checking: cmd[9:8] is passed through unchanged. The RAM decodes 00/01/10/11.
- tx_valid outside the wait phase of READ_DATA is ignored; MISO stays 0.
- Boundary cases:
  - SS_n rising during MISO shift-out: abort immediately, MISO=0, rd_addr_seen stays 1.
  - SS_n rising at the 10th-bit edge itself: the frame is aborted and rx_valid is not issued.
- Latency: rx_valid is visible in the cycle after the 10th MOSI bit is sampled. MISO MSB is visible in the cycle after tx_valid.
- Bit counter is 4 bits wide and is cleared on every state change.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- Defined: adds output port frame_err (1 bit, reset 0).
  - Pulses for one cycle when SS_n aborts a frame in WRITE, READ_ADD or READ_DATA before it completes.
  - In READ_DATA, a frame is complete only after the last MISO bit.
- Undefined: no frame_err port; aborts are silent.

Decomposition:
- Package spi_pkg holds:
  - state enum spi_state_e (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - RX_WIDTH/TX_WIDTH defaults.
- One sub-module: spi_tx_serializer (load on tx_valid, 8-bit MSB-first shift, done flag), instantiated by spi_slave_if.

Test Plan:
- Reset mid-READ_DATA shift (rst_n=0 asynchronously) -> MISO=0, rx_valid=0, state IDLE immediately; next read frame goes to READ_ADD.
- Write address: SS_n=0, MOSI=0 then 00_0011_1010 -> rx_data=10'h03A, rx_valid high for exactly 1 cycle, no MISO activity.
- Read address then read data:
  - Frame with MOSI=1 then 10_0011_1010 -> rx_data=10'h23A.
  - Next frame with MOSI=1 then 11_0000_0000 -> rx_data=10'h300, rx_valid pulses.
  - tx_valid with tx_data=8'hA5 -> MISO = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
- Abort: SS_n=1 after 5 WRITE bits -> no rx_valid, state IDLE; with SPI_FRAME_ERR_EN, frame_err pulses once.
- Read-data without prior read-address: after reset, frame with MOSI=1 -> enters READ_ADD, not READ_DATA, so rd_addr_seen must be 1 before any READ_DATA.
- Spurious tx_valid=1 with tx_data=8'hFF while in WRITE -> MISO stays 0, no state change.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave front-end of the command RAM.
//   spi_state_e : frame-level FSM states of spi_slave_if
//   spi_cmd_e   : command codes carried in rx_data[9:8]; the RAM decodes them
//   *_WIDTH_DEF : default command-word and read-data widths
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int RX_WIDTH_DEF = 10;
    localparam int TX_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// -----------------------------------------------------------------------------
// spi_tx_serializer
// Loads a read-data word and shifts it out MSB first, one bit per clock.
// The MSB appears on serial_out the cycle after load; each bit is held for
// one cycle, and once the LSB has been held serial_out returns to 0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous abort, forces serial_out low and goes idle
//   load, data  : capture data and start shifting
//   serial_out  : registered serial output
//   done        : high while the last bit is on serial_out
// -----------------------------------------------------------------------------
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int WIDTH = TX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             serial_out,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    remaining;  // bits still to present after the current one
    logic             busy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            serial_out <= 1'b0;
        end else if (clear) begin
            shreg      <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            serial_out <= 1'b0;
        end else if (load) begin
            serial_out <= data[WIDTH-1];
            shreg      <= {data[WIDTH-2:0], 1'b0};
            remaining  <= CW'(WIDTH - 1);
            busy       <= 1'b1;
        end else if (busy) begin
            if (remaining != '0) begin
                serial_out <= shreg[WIDTH-1];
                shreg      <= {shreg[WIDTH-2:0], 1'b0};
                remaining  <= remaining - 1'b1;
            end else begin
                serial_out <= 1'b0;
                busy       <= 1'b0;
            end
        end
    end

    assign done = busy && (remaining == '0);

endmodule

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// SPI slave front-end for the command RAM. clk doubles as the SPI bit clock.
// Each SS_n-low frame carries a rd/wr bit followed by a 10-bit command word
// (MSB first) that is handed to the RAM with a one-cycle rx_valid strobe.
// A read frame issued after a read-address frame is a read-data frame: the
// RAM answers with tx_valid/tx_data, which is shifted out on MISO MSB first.
// SS_n high aborts any frame in progress.
// Ports:
//   clk, rst_n          : clock / SPI bit clock, asynchronous active-low reset
//   SS_n, MOSI, MISO    : SPI slave select, serial in, serial out
//   rx_data, rx_valid   : command word to the RAM and its qualifying strobe
//   tx_data, tx_valid   : read data from the RAM and its qualifying strobe
//   frame_err           : only with SPI_FRAME_ERR_EN defined; one-cycle pulse
//                         when SS_n aborts an unfinished WRITE/READ_ADD/READ_DATA
// -----------------------------------------------------------------------------
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int RX_WIDTH = RX_WIDTH_DEF,
    parameter int TX_WIDTH = TX_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                frame_err
`endif
);

    // Counter milestones within a frame state. Values below CNT_WAIT count
    // received bits; READ_DATA then steps through wait, output and done.
    localparam logic [3:0] CNT_LAST_BIT = 4'(RX_WIDTH - 1);
    localparam logic [3:0] CNT_WAIT     = 4'(RX_WIDTH);
    localparam logic [3:0] CNT_OUT      = 4'(RX_WIDTH + 1);
    localparam logic [3:0] CNT_DONE     = 4'(RX_WIDTH + 2);

    spi_state_e          state, state_next;
    logic [3:0]          cnt;
    logic [RX_WIDTH-2:0] shift_reg;
    logic                rd_addr_seen;
    logic                shift_en, word_done, ser_load, out_done, ser_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        ser_load   = 1'b0;
        out_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              state_next = IDLE;
                else if (!MOSI)        state_next = WRITE;
                else if (rd_addr_seen) state_next = READ_DATA;
                else                   state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_next = IDLE;
                end else if (cnt < CNT_WAIT) begin
                    shift_en  = 1'b1;
                    word_done = (cnt == CNT_LAST_BIT);
                end else if (state == READ_DATA) begin
                    ser_load = (cnt == CNT_WAIT) && tx_valid;
                    out_done = (cnt == CNT_OUT) && ser_done;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
        end else begin
            rx_valid <= word_done;

            if (state_next != state)               cnt <= '0;
            else if (shift_en || ser_load || out_done) cnt <= cnt + 1'b1;

            if (shift_en)  shift_reg <= {shift_reg[RX_WIDTH-3:0], MOSI};
            if (word_done) rx_data   <= {shift_reg, MOSI};

            // An aborted frame never reaches word_done/out_done, so the flag
            // survives SS_n aborts untouched.
            if (word_done && state == READ_ADD) rd_addr_seen <= 1'b1;
            else if (out_done)                  rd_addr_seen <= 1'b0;
        end
    end

    // SS_n high aborts whatever is being shifted; outside READ_DATA the
    // serializer is already idle so clearing it there is harmless.
    spi_tx_serializer #(
        .WIDTH (TX_WIDTH)
    ) u_tx_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (SS_n),
        .load       (ser_load),
        .data       (tx_data),
        .serial_out (MISO),
        .done       (ser_done)
    );

`ifdef SPI_FRAME_ERR_EN
    logic frame_open;

    always_comb begin
        frame_open = 1'b0;
        case (state)
            WRITE, READ_ADD: frame_open = (cnt < CNT_WAIT);
            READ_DATA:       frame_open = (cnt != CNT_DONE);
            default:         frame_open = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= SS_n && frame_open;
    end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
// Drives SPI frames on the falling edge and samples the DUT 1 ns after the
// rising edge. The driver predicts each frame's outcome from the frame rules
// (rd/wr bit, bit count, read-address history) and queues the expected
// command word and MISO byte; an independent monitor pops and compares.
// Define SPI_FRAME_ERR_EN to also check the frame_err pulse count.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;
    import spi_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         nbits;   // bits expected on MISO before it returns to 0
    } miso_exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ferr = 0;
    int got_ferr = 0;
    bit seen     = 1'b0;   // model: a read-address frame has completed

    logic [9:0] rx_q[$];
    miso_exp_t  miso_q[$];

    always #5 clk = ~clk;

    spi_slave_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One SS_n-low frame. ndata < 10 aborts after that many data bits.
    // For a read-data frame, k is the number of falling edges after tx_valid
    // is raised before SS_n (or rst_n when rst_abort) ends the frame.
    task automatic send_frame(input logic rw, input logic [9:0] word, input int ndata,
                              input bit spurious, input int k, input bit rst_abort,
                              input logic [7:0] txb);
        bit rd_data;
        int d;
        rd_data = rw && (ndata == 10) && seen;
        if (ndata == 10) rx_q.push_back(word);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        @(negedge clk);
        MOSI = rw;
        @(negedge clk);
        for (int i = 0; i < ndata; i++) begin
            MOSI     = word[9-i];
            tx_valid = spurious && (i == 3);
            tx_data  = 8'hFF;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        if (ndata < 10) begin
            exp_ferr++;
        end else if (!rd_data) begin
            if (rw) seen = 1'b1;
            // RAM-style response that the DUT must ignore here.
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            @(negedge clk);
            tx_valid = 1'b0;
        end else begin
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            tx_data  = txb;
            tx_valid = 1'b1;
            miso_q.push_back('{data: txb, nbits: (k < 8) ? k : 8});
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                tx_valid = 1'b0;
            end
            if (rst_abort) begin
                rst_n = 1'b0;
                seen  = 1'b0;
                #1;
                check("rst_async_miso", MISO, 0);
                check("rst_async_rx_valid", rx_valid, 0);
                check("rst_async_rx_data", rx_data, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end else if (k >= 9) begin
                seen = 1'b0;
            end else begin
                exp_ferr++;
            end
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compares every rx_valid strobe and every MISO cycle.
    initial begin
        miso_exp_t cur;
        int        bit_i;
        bit        capturing;
        logic [9:0] exp_w;
        capturing = 1'b0;
        bit_i     = 0;
        forever begin
            @(posedge clk);
            #1;
`ifdef SPI_FRAME_ERR_EN
            if (frame_err === 1'b1) got_ferr++;
`endif
            if (rx_valid === 1'b1) begin
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got rx_valid=1 rx_data=0x%0h expected no strobe", rx_data);
                end else begin
                    exp_w = rx_q.pop_front();
                    check("rx_data", rx_data, exp_w);
                end
            end
            if (capturing) begin
                if (bit_i < cur.nbits) begin
                    check("miso_bit", MISO, cur.data[7-bit_i]);
                end else begin
                    check("miso_tail", MISO, 0);
                    capturing = 1'b0;
                end
                bit_i++;
            end else if (tx_valid === 1'b1 && miso_q.size() != 0) begin
                cur = miso_q.pop_front();
                check("miso_msb", MISO, cur.data[7]);
                bit_i     = 1;
                capturing = 1'b1;
            end else begin
                check("miso_idle", MISO, 0);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_miso", MISO, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address with a spurious tx_valid mid-frame.
        send_frame(1'b0, {CMD_WR_ADDR, 8'h3A}, 10, 1'b1, 0, 1'b0, 8'h00);
        // Read address, then read data returning 0xA5 in full.
        send_frame(1'b1, {CMD_RD_ADDR, 8'h3A}, 10, 1'b0, 0, 1'b0, 8'h00);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 10, 1'b0, 8'hA5);
        // Abort after 5 write bits.
        send_frame(1'b0, {CMD_WR_DATA, 8'h5C}, 5, 1'b0, 0, 1'b0, 8'h00);
        // Read address, read data aborted during MISO shift-out, then a
        // further read frame goes straight to READ_DATA.
        send_frame(1'b1, {CMD_RD_ADDR, 8'h11}, 10, 1'b0, 0, 1'b0, 8'h00);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 4, 1'b0, 8'hC3);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 9, 1'b0, 0, 1'b0, 8'h00);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 9, 1'b0, 8'h96);
        // Async reset mid shift-out; the next read frame must be READ_ADD.
        send_frame(1'b1, {CMD_RD_ADDR, 8'h42}, 10, 1'b0, 0, 1'b0, 8'h00);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 3, 1'b1, 8'h7E);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 10, 1'b0, 8'h81);
        send_frame(1'b1, {CMD_RD_DATA, 8'h00}, 10, 1'b0, 10, 1'b0, 8'h5A);

        for (int n = 0; n < 40; n++) begin
            int nd;
            nd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 10;
            send_frame(1'($urandom), 10'($urandom), nd, 1'($urandom),
                       $urandom_range(1, 12), 1'b0, 8'($urandom));
        end

        repeat (4) @(negedge clk);
        check("rx_queue_drained", rx_q.size(), 0);
        check("miso_queue_drained", miso_q.size(), 0);
`ifdef SPI_FRAME_ERR_EN
        check("frame_err_count", got_ferr, exp_ferr);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
